// File: rtl/vdp_cartridge_pkg.sv
// Purpose: shared types and constants for the VDP cartridge slot interface.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package vdp_cartridge_pkg;

    // Slot I/O cycle sequencer states
    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        RD_REQ,
        RD_DATA,
        DRIVE,
        TURN,
        RELEASE
    } slot_state_t;

    // VDP port offsets within the 4-port I/O window (bus_address values)
    typedef enum logic [1:0] {
        PORT_VRAM_DATA = 2'd0,
        PORT_CONTROL   = 2'd1,
        PORT_PALETTE   = 2'd2,
        PORT_INDIRECT  = 2'd3
    } vdp_port_t;

    localparam logic [7:0] DEFAULT_IO_BASE = 8'h98;
    localparam logic [7:0] DEFAULT_IO_MASK = 8'hFC;

    // Value returned to the host when a read gets no answer in time
    localparam logic [7:0] FLOAT_DATA = 8'hFF;

    function automatic logic io_hit(input logic [7:0] addr,
                                    input logic [7:0] base,
                                    input logic [7:0] mask);
        return (addr & mask) == (base & mask);
    endfunction

endpackage

// File: rtl/slot_strobe_sync.sv
// Purpose: 2-FF synchronisers for IORQ_n/RD_n/WR_n plus start-of-cycle detect.
// Latency: synced levels 2 clk after the raw strobe; rd_start/wr_start combinational from them.
// Backpressure: none; free-running.
// Ports: clk, reset_n; raw iorq_n/rd_n/wr_n in; synced iorq_s/rd_s/wr_s (active-low) and
//        rd_start/wr_start single-cycle pulses out.
module slot_strobe_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic iorq_n,
    input  logic rd_n,
    input  logic wr_n,
    output logic iorq_s,
    output logic rd_s,
    output logic wr_s,
    output logic rd_start,
    output logic wr_start
);
    // bit order {iorq, rd, wr}; idle level of every strobe is high
    logic [2:0] meta;
    logic [2:0] sync;
    logic [2:0] prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 3'b111;
            sync <= 3'b111;
            prev <= 3'b111;
        end else begin
            meta <= {iorq_n, rd_n, wr_n};
            sync <= meta;
            prev <= sync;
        end
    end

    assign iorq_s = sync[2];
    assign rd_s   = sync[1];
    assign wr_s   = sync[0];

    // A cycle starts when both strobes are low now and were both high one sync cycle ago
    assign rd_start = !sync[2] && !sync[1] && prev[2] && prev[1];
    assign wr_start = !sync[2] && !sync[0] && prev[2] && prev[0];

endmodule

// File: rtl/msx_slot_io_controller.sv
// Purpose: turns MSX slot I/O cycles in the VDP window into valid/ready register-bus requests.
// Latency: bus_valid/slot_wait rise on the 3rd clk edge after the raw strobes fall.
// Backpressure: slot_wait holds the Z80 until the bus accepts (write) or returns data (read).
// Ports: clk/reset_n; slot strobes, address and data pads; shifter controls oe_n/slot_data_dir,
//        busdir, slot_wait; bus_valid/ready request with rdata strobe; timeout pulse.
module msx_slot_io_controller
    import vdp_cartridge_pkg::*;
#(
    parameter logic [7:0] IO_BASE  = DEFAULT_IO_BASE,
    parameter logic [7:0] IO_MASK  = DEFAULT_IO_MASK,
    parameter int         WAIT_MAX = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       slot_iorq_n,
    input  logic       slot_rd_n,
    input  logic       slot_wr_n,
    input  logic [7:0] slot_a,
    input  logic [7:0] slot_d_in,
    output logic [7:0] slot_d_out,
    output logic       slot_d_oe,
    output logic       slot_data_dir,
    output logic       oe_n,
    output logic       busdir,
    output logic       slot_wait,
    output logic       bus_valid,
    output logic       bus_write,
    output logic [1:0] bus_address,
    output logic [7:0] bus_wdata,
    input  logic       bus_ready,
    input  logic [7:0] bus_rdata,
    input  logic       bus_rdata_en,
    output logic       timeout
);
    localparam int             CW        = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0]  WAIT_LAST = CW'(WAIT_MAX - 1);

    logic        iorq_s, rd_s, wr_s, rd_start, wr_start;
    slot_state_t state;
    logic [CW-1:0] wait_cnt;
    logic        drive_on;   // second DRIVE cycle reached: pads enabled
    logic        rd_owed;    // read accepted by the bus, data not yet returned
    logic        wait_expired;

    slot_strobe_sync u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .iorq_n   (slot_iorq_n),
        .rd_n     (slot_rd_n),
        .wr_n     (slot_wr_n),
        .iorq_s   (iorq_s),
        .rd_s     (rd_s),
        .wr_s     (wr_s),
        .rd_start (rd_start),
        .wr_start (wr_start)
    );

    // Shifter is always enabled; direction alone decides who drives
    assign oe_n = 1'b0;

    assign wait_expired = slot_wait && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            slot_d_out    <= '0;
            slot_d_oe     <= 1'b0;
            slot_data_dir <= 1'b0;
            busdir        <= 1'b0;
            slot_wait     <= 1'b0;
            bus_valid     <= 1'b0;
            bus_write     <= 1'b0;
            bus_address   <= '0;
            bus_wdata     <= '0;
            timeout       <= 1'b0;
            wait_cnt      <= '0;
            drive_on      <= 1'b0;
            rd_owed       <= 1'b0;
        end else begin
            timeout  <= 1'b0;
            wait_cnt <= slot_wait ? wait_cnt + 1'b1 : '0;

            // Request retirement and owed-data tracking run in every state so that
            // reads abandoned by timeout or host abort are still drained cleanly.
            if (bus_valid && bus_ready)
                bus_valid <= 1'b0;
            if (bus_valid && bus_ready && !bus_write && !bus_rdata_en)
                rd_owed <= 1'b1;
            else if (bus_rdata_en)
                rd_owed <= 1'b0;

            case (state)
                IDLE: begin
                    if (rd_start || wr_start) begin
                        if (!rd_s && !wr_s) begin
                            state <= RELEASE;           // both strobes low: invalid
                        end else if (!io_hit(slot_a, IO_BASE, IO_MASK)) begin
                            state <= RELEASE;
                        end else begin
                            bus_valid   <= 1'b1;
                            bus_write   <= wr_start;
                            bus_address <= slot_a[1:0];
                            slot_wait   <= 1'b1;
                            if (wr_start)
                                bus_wdata <= slot_d_in;
                            state <= wr_start ? WR_REQ : RD_REQ;
                        end
                    end
                end

                WR_REQ: begin
                    if (bus_valid && bus_ready) begin
                        slot_wait <= 1'b0;
                        state     <= RELEASE;
                    end else if (wait_expired) begin
                        // host is freed but the request stays up until accepted
                        slot_wait <= 1'b0;
                        timeout   <= 1'b1;
                    end
                end

                RD_REQ, RD_DATA: begin
                    if (iorq_s) begin
                        slot_wait <= 1'b0;              // host gave up: never drive
                        state     <= RELEASE;
                    end else if (bus_rdata_en && (state == RD_DATA || (bus_valid && bus_ready))) begin
                        slot_d_out    <= bus_rdata;
                        slot_data_dir <= 1'b1;
                        busdir        <= 1'b1;
                        state         <= DRIVE;
                    end else if (wait_expired) begin
                        slot_wait     <= 1'b0;
                        timeout       <= 1'b1;
                        slot_d_out    <= FLOAT_DATA;
                        slot_data_dir <= 1'b1;
                        busdir        <= 1'b1;
                        state         <= DRIVE;
                    end else if (state == RD_REQ && bus_valid && bus_ready) begin
                        state <= RD_DATA;
                    end
                end

                DRIVE: begin
                    // direction flips one cycle before the pads enable
                    if (!drive_on) begin
                        drive_on  <= 1'b1;
                        slot_d_oe <= 1'b1;
                        slot_wait <= 1'b0;
                    end else if (rd_s || iorq_s) begin
                        drive_on  <= 1'b0;
                        slot_d_oe <= 1'b0;
                        state     <= TURN;
                    end
                end

                TURN: begin
                    // pads already off; now hand the shifter back to slot->FPGA
                    slot_data_dir <= 1'b0;
                    busdir        <= 1'b0;
                    state         <= RELEASE;
                end

                RELEASE: begin
                    if (iorq_s && !bus_valid && !rd_owed)
                        state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_msx_slot_io_controller.sv
// Purpose: directed self-checking bench for msx_slot_io_controller.
// Latency: n/a.
// Backpressure: bus_ready/bus_rdata_en driven per scenario.
module tb_msx_slot_io_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       slot_iorq_n, slot_rd_n, slot_wr_n;
    logic [7:0] slot_a, slot_d_in;
    logic [7:0] slot_d_out;
    logic       slot_d_oe, slot_data_dir, oe_n, busdir, slot_wait;
    logic       bus_valid, bus_write;
    logic [1:0] bus_address;
    logic [7:0] bus_wdata;
    logic       bus_ready;
    logic [7:0] bus_rdata;
    logic       bus_rdata_en;
    logic       timeout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    msx_slot_io_controller #(
        .IO_BASE (8'h98),
        .IO_MASK (8'hFC),
        .WAIT_MAX(64)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .slot_iorq_n  (slot_iorq_n),
        .slot_rd_n    (slot_rd_n),
        .slot_wr_n    (slot_wr_n),
        .slot_a       (slot_a),
        .slot_d_in    (slot_d_in),
        .slot_d_out   (slot_d_out),
        .slot_d_oe    (slot_d_oe),
        .slot_data_dir(slot_data_dir),
        .oe_n         (oe_n),
        .busdir       (busdir),
        .slot_wait    (slot_wait),
        .bus_valid    (bus_valid),
        .bus_write    (bus_write),
        .bus_address  (bus_address),
        .bus_wdata    (bus_wdata),
        .bus_ready    (bus_ready),
        .bus_rdata    (bus_rdata),
        .bus_rdata_en (bus_rdata_en),
        .timeout      (timeout)
    );

    task automatic release_host();
        slot_iorq_n = 1'b1;
        slot_rd_n   = 1'b1;
        slot_wr_n   = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        release_host();
        slot_a = 8'h00; slot_d_in = 8'h00;
        bus_ready = 1'b0; bus_rdata = 8'h00; bus_rdata_en = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({slot_d_out, slot_d_oe, slot_data_dir, oe_n, busdir} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_pads got d_out=%h oe=%b dir=%b oe_n=%b busdir=%b want all 0",
                     slot_d_out, slot_d_oe, slot_data_dir, oe_n, busdir);
        end
        n_tests++;
        if ({slot_wait, bus_valid, bus_write, bus_address, bus_wdata, timeout} !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_bus got wait=%b valid=%b write=%b addr=%h wdata=%h to=%b want all 0",
                     slot_wait, bus_valid, bus_write, bus_address, bus_wdata, timeout);
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_write();
        int vcnt = 0, acc = 0, fbad = 0, wbad = 0, drv = 0, tocnt = 0;
        slot_a = 8'h99; slot_d_in = 8'h5A;
        @(negedge clk);
        slot_iorq_n = 1'b0; slot_wr_n = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus_valid !== 1'b0) begin
            n_fail++; $display("FAIL wr_early got valid=%b want 0", bus_valid);
        end
        @(negedge clk);
        n_tests++;
        if (bus_valid !== 1'b1 || slot_wait !== 1'b1) begin
            n_fail++; $display("FAIL wr_latency got valid=%b wait=%b want 1 1", bus_valid, slot_wait);
        end
        for (int c = 0; c < 12; c++) begin
            if (acc == 0 && slot_wait !== 1'b1) wbad++;
            if (acc > 0 && slot_wait !== 1'b0) wbad++;
            if (bus_valid === 1'b1) begin
                vcnt++;
                if (bus_write !== 1'b1 || bus_address !== 2'd1 || bus_wdata !== 8'h5A) fbad++;
            end
            if (slot_d_oe !== 1'b0 || slot_data_dir !== 1'b0 || busdir !== 1'b0 || oe_n !== 1'b0) drv++;
            if (timeout !== 1'b0) tocnt++;
            if (bus_valid === 1'b1 && vcnt == 6) bus_ready = 1'b1;
            if (bus_valid === 1'b1 && bus_ready === 1'b1) acc++;
            @(negedge clk);
            bus_ready = 1'b0;
        end
        n_tests++;
        if (vcnt != 6) begin n_fail++; $display("FAIL wr_valid_cycles got %0d want 6", vcnt); end
        n_tests++;
        if (acc != 1) begin n_fail++; $display("FAIL wr_accepts got %0d want 1", acc); end
        n_tests++;
        if (fbad != 0) begin n_fail++; $display("FAIL wr_fields got %0d bad cycles want 0", fbad); end
        n_tests++;
        if (wbad != 0) begin n_fail++; $display("FAIL wr_wait got %0d bad cycles want 0", wbad); end
        n_tests++;
        if (drv != 0 || tocnt != 0) begin
            n_fail++; $display("FAIL wr_no_drive got drive=%0d timeout=%0d want 0 0", drv, tocnt);
        end
        release_host();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_read();
        slot_a = 8'h98;
        @(negedge clk);
        slot_iorq_n = 1'b0; slot_rd_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus_valid !== 1'b1 || bus_write !== 1'b0 || bus_address !== 2'd0 || slot_wait !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_request got valid=%b write=%b addr=%h wait=%b want 1 0 0 1",
                     bus_valid, bus_write, bus_address, slot_wait);
        end
        bus_ready = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0;
        n_tests++;
        if (bus_valid !== 1'b0 || slot_wait !== 1'b1 || slot_data_dir !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_accepted got valid=%b wait=%b dir=%b want 0 1 0", bus_valid, slot_wait, slot_data_dir);
        end
        repeat (3) @(negedge clk);
        bus_rdata = 8'hC3; bus_rdata_en = 1'b1;
        @(negedge clk);
        bus_rdata_en = 1'b0;
        n_tests++;
        if (slot_data_dir !== 1'b1 || busdir !== 1'b1 || slot_d_oe !== 1'b0 || slot_wait !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_dir_first got dir=%b busdir=%b d_oe=%b wait=%b want 1 1 0 1",
                     slot_data_dir, busdir, slot_d_oe, slot_wait);
        end
        @(negedge clk);
        n_tests++;
        if (slot_d_oe !== 1'b1 || slot_wait !== 1'b0 || slot_d_out !== 8'hC3 || slot_data_dir !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_drive got d_oe=%b wait=%b d_out=%h dir=%b want 1 0 c3 1",
                     slot_d_oe, slot_wait, slot_d_out, slot_data_dir);
        end
        repeat (2) @(negedge clk);
        release_host();
        repeat (2) @(negedge clk);
        n_tests++;
        if (slot_d_oe !== 1'b1) begin
            n_fail++; $display("FAIL rd_hold got d_oe=%b want 1", slot_d_oe);
        end
        @(negedge clk);
        n_tests++;
        if (slot_d_oe !== 1'b0 || slot_data_dir !== 1'b1) begin
            n_fail++; $display("FAIL rd_turn got d_oe=%b dir=%b want 0 1", slot_d_oe, slot_data_dir);
        end
        @(negedge clk);
        n_tests++;
        if (slot_data_dir !== 1'b0 || busdir !== 1'b0) begin
            n_fail++; $display("FAIL rd_dir_back got dir=%b busdir=%b want 0 0", slot_data_dir, busdir);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_miss();
        int bad;
        for (int k = 0; k < 2; k++) begin
            bad = 0;
            slot_a = 8'hA0; slot_d_in = 8'h77;
            @(negedge clk);
            slot_iorq_n = 1'b0;
            if (k == 0) slot_rd_n = 1'b0;
            else        slot_wr_n = 1'b0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (bus_valid !== 1'b0 || slot_wait !== 1'b0 || slot_data_dir !== 1'b0 || oe_n !== 1'b0) bad++;
            end
            release_host();
            repeat (4) @(negedge clk);
            n_tests++;
            if (bad != 0) begin
                n_fail++; $display("FAIL miss_%0s got %0d bad cycles want 0", (k == 0) ? "read" : "write", bad);
            end
        end
    endtask

    task automatic test_timeout();
        int wcnt = 0, to_early = 0;
        bit dropped = 1'b0;
        slot_a = 8'h9A;
        @(negedge clk);
        slot_iorq_n = 1'b0; slot_rd_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus_valid !== 1'b1 || bus_address !== 2'd2) begin
            n_fail++; $display("FAIL to_request got valid=%b addr=%h want 1 2", bus_valid, bus_address);
        end
        for (int c = 0; c < 200 && !dropped; c++) begin
            if (slot_wait === 1'b1) begin
                wcnt++;
                if (timeout !== 1'b0) to_early++;
                @(negedge clk);
            end else begin
                dropped = 1'b1;
            end
        end
        n_tests++;
        if (!dropped || wcnt != 64 || to_early != 0) begin
            n_fail++;
            $display("FAIL to_wait_len got wait_cycles=%0d dropped=%b early=%0d want 64 1 0", wcnt, dropped, to_early);
        end
        n_tests++;
        if (timeout !== 1'b1 || slot_d_out !== 8'hFF || slot_data_dir !== 1'b1 || bus_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL to_pulse got to=%b d_out=%h dir=%b valid=%b want 1 ff 1 1",
                     timeout, slot_d_out, slot_data_dir, bus_valid);
        end
        @(negedge clk);
        n_tests++;
        if (timeout !== 1'b0 || slot_d_oe !== 1'b1 || slot_d_out !== 8'hFF) begin
            n_fail++;
            $display("FAIL to_float_drive got to=%b d_oe=%b d_out=%h want 0 1 ff", timeout, slot_d_oe, slot_d_out);
        end
        release_host();
        repeat (5) @(negedge clk);
        n_tests++;
        if (slot_d_oe !== 1'b0 || slot_data_dir !== 1'b0 || bus_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL to_valid_held got d_oe=%b dir=%b valid=%b want 0 0 1", slot_d_oe, slot_data_dir, bus_valid);
        end
        bus_ready = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0;
        bus_rdata = 8'h11; bus_rdata_en = 1'b1;
        @(negedge clk);
        bus_rdata_en = 1'b0;
        n_tests++;
        if (bus_valid !== 1'b0 || slot_d_out !== 8'hFF || slot_d_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL to_late_discard got valid=%b d_out=%h d_oe=%b want 0 ff 0", bus_valid, slot_d_out, slot_d_oe);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_in_drive();
        slot_a = 8'h9B;
        @(negedge clk);
        slot_iorq_n = 1'b0; slot_rd_n = 1'b0;
        repeat (3) @(negedge clk);
        bus_ready = 1'b1; bus_rdata = 8'h3C; bus_rdata_en = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0; bus_rdata_en = 1'b0;
        n_tests++;
        if (slot_data_dir !== 1'b1 || slot_d_out !== 8'h3C) begin
            n_fail++; $display("FAIL rst_same_cycle_data got dir=%b d_out=%h want 1 3c", slot_data_dir, slot_d_out);
        end
        @(negedge clk);
        n_tests++;
        if (slot_d_oe !== 1'b1) begin
            n_fail++; $display("FAIL rst_in_drive got d_oe=%b want 1", slot_d_oe);
        end
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({slot_d_oe, slot_data_dir, busdir, slot_wait, bus_valid} !== 5'b0) begin
            n_fail++;
            $display("FAIL rst_async got d_oe=%b dir=%b busdir=%b wait=%b valid=%b want all 0",
                     slot_d_oe, slot_data_dir, busdir, slot_wait, bus_valid);
        end
        release_host();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        slot_a = 8'h98;
        @(negedge clk);
        slot_iorq_n = 1'b0; slot_rd_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus_valid !== 1'b1 || bus_write !== 1'b0) begin
            n_fail++; $display("FAIL rst_next_request got valid=%b write=%b want 1 0", bus_valid, bus_write);
        end
        bus_ready = 1'b1; bus_rdata = 8'h5C; bus_rdata_en = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0; bus_rdata_en = 1'b0;
        @(negedge clk);
        n_tests++;
        if (slot_d_oe !== 1'b1 || slot_d_out !== 8'h5C || slot_wait !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_next_drive got d_oe=%b d_out=%h wait=%b want 1 5c 0", slot_d_oe, slot_d_out, slot_wait);
        end
        release_host();
        repeat (6) @(negedge clk);
        n_tests++;
        if (slot_d_oe !== 1'b0 || slot_data_dir !== 1'b0) begin
            n_fail++; $display("FAIL rst_next_release got d_oe=%b dir=%b want 0 0", slot_d_oe, slot_data_dir);
        end
    endtask

    task automatic test_rd_wr_together();
        int bad = 0;
        slot_a = 8'h98;
        @(negedge clk);
        slot_iorq_n = 1'b0; slot_rd_n = 1'b0; slot_wr_n = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus_valid !== 1'b0 || slot_wait !== 1'b0 || slot_d_oe !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL rdwr_no_request got %0d bad cycles want 0", bad); end
        release_host();
        repeat (4) @(negedge clk);
        slot_a = 8'h9B; slot_d_in = 8'hA5;
        @(negedge clk);
        slot_iorq_n = 1'b0; slot_wr_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus_valid !== 1'b1 || bus_write !== 1'b1 || bus_address !== 2'd3 || bus_wdata !== 8'hA5) begin
            n_fail++;
            $display("FAIL rdwr_back_to_idle got valid=%b write=%b addr=%h wdata=%h want 1 1 3 a5",
                     bus_valid, bus_write, bus_address, bus_wdata);
        end
        bus_ready = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0;
        n_tests++;
        if (bus_valid !== 1'b0 || slot_wait !== 1'b0) begin
            n_fail++; $display("FAIL rdwr_write_done got valid=%b wait=%b want 0 0", bus_valid, slot_wait);
        end
        release_host();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_miss();
        test_timeout();
        test_reset_in_drive();
        test_rd_wr_together();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/msx_slot_io_controller.md
Name: msx_slot_io_controller

Overview:
- Sequences MSX slot I/O cycles for the VDP cartridge.
- Synchronises the asynchronous slot strobes into the 27 MHz `clk` domain and decodes the VDP I/O port window.
- Converts each decoded host access into a single valid/ready request to the internal VDP register bus.
- Owns the data-bus level shifter (`oe_n`, `slot_data_dir`), the FPGA pad tristate, `busdir` and `slot_wait`.

Parameters:
- IO_BASE, 8'h98, base I/O address of the VDP window.
- IO_MASK, 8'hFC, address bits compared for decode; 4 ports.
- WAIT_MAX, 64, clk cycles `slot_wait` may be held before timeout; counter width $clog2(WAIT_MAX+1).

Ports:
- clk  in  1  27 MHz system clock
- reset_n  in  1  asynchronous, active-low reset
- slot_iorq_n  in  1  raw slot IORQ_n
- slot_rd_n  in  1  raw slot RD_n
- slot_wr_n  in  1  raw slot WR_n
- slot_a  in  8  slot address A7..A0
- slot_d_in  in  8  data from slot pads
- slot_d_out  out  8  data to slot pads
- slot_d_oe  out  1  pad tristate enable
- slot_data_dir  out  1  level shifter direction; 1 = FPGA->slot
- oe_n  out  1  level shifter enable, active-low
- busdir  out  1  1 while the cartridge drives read data
- slot_wait  out  1  1 = hold the Z80
- bus_valid  out  1  request valid
- bus_write  out  1  1 = write, 0 = read
- bus_address  out  2  port offset, slot_a[1:0]
- bus_wdata  out  8  write data
- bus_ready  in  1  request accepted
- bus_rdata  in  8  read data
- bus_rdata_en  in  1  one-cycle read data strobe
- timeout  out  1  one-cycle pulse when WAIT_MAX expires

Behaviour:
- Reset (async) values: slot_d_out=0, slot_d_oe=0, slot_data_dir=0, oe_n=0, busdir=0, slot_wait=0, bus_valid=0, bus_write=0, bus_address=0, bus_wdata=0, timeout=0, state=IDLE.
- The shifter stays enabled in the slot->FPGA direction by default so write data can be sampled.
- Strobe sync: iorq_n, rd_n and wr_n each pass through 2 FFs.
- Cycle start:
  - rd_start = synced iorq low and rd low, after both iorq and rd were high in the previous synced cycle.
  - wr_start is the same with wr.
  - rd and wr both low in the same cycle is invalid: no request, go to RELEASE.
- Decode: at start, hit = ((slot_a & IO_MASK) == (IO_BASE & IO_MASK)). slot_a and slot_d_in are sampled in that cycle; they are stable because the host asserts them before the strobes.
- Latency: bus_valid and slot_wait rise on the 3rd clk edge after the raw strobes fall (2 sync stages + registered start).
- IDLE: on miss go to RELEASE; on a write hit go to WR_REQ; on a read hit go to RD_REQ.
- WR_REQ: bus_valid=1, bus_write=1, address and data latched. On valid&ready: bus_valid=0, slot_wait=0 next cycle, go to RELEASE.
- RD_REQ: bus_valid=1, bus_write=0. On valid&ready go to RD_DATA. bus_rdata_en arriving in the same cycle as ready is accepted.
- RD_DATA: on bus_rdata_en latch bus_rdata into slot_d_out and go to DRIVE.
- DRIVE:
  - Cycle 1: slot_data_dir=1, busdir=1.
  - Next cycle: slot_d_oe=1, slot_wait=0.
  - Hold until synced rd_n or iorq_n is high, then go to TURN.
- TURN:
  - Cycle 1: slot_d_oe=0.
  - Next cycle: slot_data_dir=0, busdir=0, go to RELEASE.
  - Pad and shifter are never both driving.
- RELEASE: wait until synced iorq_n is high, then go to IDLE. This gives one request per host cycle.
- Request rules:
  - Valid is never retracted before ready.
  - address, wdata and write stay stable while valid.
- Timeout: the counter runs while slot_wait=1. At WAIT_MAX:
  - slot_wait drops and timeout pulses.
  - On a read, slot_d_out=8'hFF and go to DRIVE. A late bus_rdata_en is discarded.
  - On a write, valid stays asserted until ready.
- Host abort (iorq_n high before data on a read): no drive; discard the pending rdata and go to IDLE after it arrives.
- reset_n low in any state returns all outputs to reset values immediately, which releases the pads.

Decomposition:
- Shared package `vdp_cartridge_pkg`:
  - state encoding: IDLE, WR_REQ, RD_REQ, RD_DATA, DRIVE, TURN, RELEASE
  - VDP port offsets: 0 VRAM data, 1 control, 2 palette, 3 indirect register
  - default IO_BASE/IO_MASK
  - the 8'hFF float value
- Sub-module `slot_strobe_sync`: 2-FF synchronisers plus the rd_start/wr_start edge detect.

Test Plan:
- Write 0x5A to port 0x99, ready after 5 cycles -> exactly one valid, write=1, address=1, wdata=0x5A; slot_wait high until the cycle after accept; no pad drive.
- Read port 0x98, rdata=0xC3 four cycles after ready -> slot_d_out=0xC3, dir then oe 1 cycle apart, busdir=1, wait drops with d_oe; after rd_n high, d_oe=0 one cycle before dir=0.
- Access port 0xA0 (read and write) -> no bus_valid, slot_wait=0, dir=0, oe_n=0 throughout.
- Read 0x9A with ready never asserted -> timeout pulse at cycle WAIT_MAX, slot_d_out=0xFF driven, wait released.
- Assert reset_n low during DRIVE -> d_oe, dir, busdir, wait and valid are 0 asynchronously; the next host read works normally.
- Drive rd_n and wr_n low together on port 0x98 -> no request, returns to IDLE after iorq_n rises.
